// File: rtl/pc_stack_block_pkg.sv
// Shared constants for the fetch-stage program-counter unit.
package pc_pkg;

   // Default geometry
   localparam int unsigned PC_WIDTH = 16;
   localparam int unsigned PC_INC   = 2;
   localparam int unsigned PC_RESET = 0;

   // Next-PC source indices; index 0 is always the internal sequential PC
   localparam int unsigned SRC_INC     = 0;
   localparam int unsigned SRC_IMM_PC  = 1;
   localparam int unsigned SRC_IMM_ADDR = 2;
   localparam int unsigned SRC_RA      = 3;
   localparam int unsigned SRC_MARY    = 4;
   localparam int unsigned SRC_PC_MARY = 5;
   localparam int unsigned SRC_JCMP    = 6;
   localparam int unsigned SRC_JCMP_LS = 7;

   typedef enum logic [2:0] {
      SrcInc     = 3'd0,
      SrcImmPc   = 3'd1,
      SrcImmAddr = 3'd2,
      SrcRa      = 3'd3,
      SrcMary    = 3'd4,
      SrcPcMary  = 3'd5,
      SrcJcmp    = 3'd6,
      SrcJcmpLs  = 3'd7
   } pc_src_e;

endpackage

// File: rtl/pc_stack_block_if.sv
// Control/status bundle between the control unit and the PC unit.
interface pc_stack_block_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NSRC  = 8,
   parameter int unsigned SRC_W = 3
);
   logic                  pc_write;
   logic [SRC_W-1:0]      pc_src;
   logic [NSRC*WIDTH-1:0] src_bus;
   logic                  jcmp;
   logic                  comp;
   logic                  push;
   logic                  pop;
   logic                  sync_clr;
   logic [WIDTH-1:0]      pc_cur;
   logic [WIDTH-1:0]      ras_top;
   logic                  ras_empty;
   logic                  ras_full;
   logic                  ras_ovf;
   logic                  ras_unf;

   // Control unit side
   modport master (
      output pc_write, pc_src, src_bus, jcmp, comp, push, pop, sync_clr,
      input  pc_cur, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
   );

   // PC unit side
   modport slave (
      input  pc_write, pc_src, src_bus, jcmp, comp, push, pop, sync_clr,
      output pc_cur, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_stack_block_ras_lifo.sv
// Return-address stack: circular buffer indexed by a top pointer, plus an
// occupancy count. A push while full overwrites the oldest entry.
module ras_lifo
   import pc_pkg::*;
#(
   parameter int unsigned     WIDTH     = PC_WIDTH,
   parameter int unsigned     DEPTH     = 8,
   parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] top_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             ovf_o,
   output logic             unf_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] tp_q, tp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;
   logic             empty;
   logic             full;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(DEPTH));

   // Next pointer/count/sticky state and the single write port
   always_comb begin
      tp_d   = tp_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      wr_en  = 1'b0;
      wr_ptr = tp_q + PTR_W'(1);
      if (clr_i) begin
         tp_d  = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         if (pop_i && empty) begin
            unf_d = 1'b1;
         end
         if (push_i && pop_i && !empty) begin
            // Return then call: replace the top in place
            wr_en  = 1'b1;
            wr_ptr = tp_q;
         end else if (push_i) begin
            wr_en = 1'b1;
            tp_d  = tp_q + PTR_W'(1);
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (pop_i && !empty) begin
            tp_d  = tp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // Pointer, count and sticky flag registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Entry storage; contents are only visible while count is non-zero
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= din_i;
      end
   end

   assign top_o   = empty ? EMPTY_VAL : mem_q[tp_q];
   assign empty_o = empty;
   assign full_o  = full;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

endmodule

// File: rtl/pc_stack_block.sv
// Fetch-stage PC unit: source mux, compare-gated suppression, PC register and
// a return-address stack for call/return.
module pc_stack_block
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH    = PC_WIDTH,
   parameter int unsigned      NSRC     = 8,
   parameter int unsigned      SRC_W    = 3,
   parameter int unsigned      DEPTH    = 8,
   parameter int unsigned      INC      = PC_INC,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET)
) (
   input logic               clk_i,
   input logic               rst_ni,
   pc_stack_block_if.slave   bus_io
);
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] sel_pc;
   logic [WIDTH-1:0] slot [NSRC];
   logic             upd;
   logic [WIDTH-1:0] ras_top;
   logic             ras_empty;
   logic             unused_slot0;

   // Bus slot 0 is ignored; the sequential PC is used for select 0
   assign slot[0]      = pc_inc;
   assign unused_slot0 = ^bus_io.src_bus[WIDTH-1:0];
   for (genvar k = 1; k < NSRC; k++) begin : g_slot
      assign slot[k] = bus_io.src_bus[k*WIDTH +: WIDTH];
   end

   assign pc_inc = pc_q + WIDTH'(INC);
   // A failed compare-jump freezes PC and RAS for this cycle
   assign upd    = bus_io.pc_write && !(bus_io.jcmp && !bus_io.comp);

   // Source select; out-of-range selects fall back to sequential
   always_comb begin
      sel_pc = pc_inc;
      if (32'(bus_io.pc_src) < NSRC) begin
         sel_pc = slot[bus_io.pc_src];
      end
   end

   // Next PC: clear > suppression > return > source select
   always_comb begin
      pc_d = pc_q;
      if (bus_io.sync_clr) begin
         pc_d = RESET_PC;
      end else if (upd) begin
         if (bus_io.pop) begin
            if (!ras_empty) begin
               pc_d = ras_top;
            end
         end else begin
            pc_d = sel_pc;
         end
      end
   end

   // PC register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   ras_lifo #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .EMPTY_VAL (RESET_PC)
   ) u_ras (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (bus_io.sync_clr),
      .push_i  (upd && bus_io.push),
      .pop_i   (upd && bus_io.pop),
      .din_i   (pc_inc),
      .top_o   (ras_top),
      .empty_o (ras_empty),
      .full_o  (bus_io.ras_full),
      .ovf_o   (bus_io.ras_ovf),
      .unf_o   (bus_io.ras_unf)
   );

   assign bus_io.pc_cur    = pc_q;
   assign bus_io.ras_top   = ras_top;
   assign bus_io.ras_empty = ras_empty;

endmodule

// File: tb/tb_pc_stack_block.sv
// Directed vector bench for pc_stack_block (WIDTH=16, NSRC=8, DEPTH=8, INC=2).
module tb_pc_stack_block;
   logic clk;
   logic rst_n;

   pc_stack_block_if #(.WIDTH(16), .NSRC(8), .SRC_W(3)) bus ();

   pc_stack_block #(
      .WIDTH    (16),
      .NSRC     (8),
      .SRC_W    (3),
      .DEPTH    (8),
      .INC      (2),
      .RESET_PC (16'h0000)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pw;
      logic [2:0]  src;
      logic        jc;
      logic        cp;
      logic        pu;
      logic        po;
      logic        sc;
      logic [15:0] s2;
      logic [15:0] e_pc;
      logic [15:0] e_top;
      logic        e_em;
      logic        e_fu;
      logic        e_ov;
      logic        e_un;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic pw, logic [2:0] src, logic jc, logic cp, logic pu,
                               logic po, logic sc, logic [15:0] s2, logic [15:0] e_pc,
                               logic [15:0] e_top, logic e_em, logic e_fu, logic e_ov,
                               logic e_un);
      vec_t v;
      v.pw = pw; v.src = src; v.jc = jc; v.cp = cp; v.pu = pu; v.po = po; v.sc = sc;
      v.s2 = s2; v.e_pc = e_pc; v.e_top = e_top; v.e_em = e_em; v.e_fu = e_fu;
      v.e_ov = e_ov; v.e_un = e_un;
      return v;
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [15:0] e_pc, logic [15:0] e_top, logic e_em,
                          logic e_fu, logic e_ov, logic e_un);
      chk({tag, " pcCur"}, bus.pc_cur, e_pc);
      chk({tag, " rasTop"}, bus.ras_top, e_top);
      chk({tag, " rasEmpty"}, 16'(bus.ras_empty), 16'(e_em));
      chk({tag, " rasFull"}, 16'(bus.ras_full), 16'(e_fu));
      chk({tag, " rasOvf"}, 16'(bus.ras_ovf), 16'(e_ov));
      chk({tag, " rasUnf"}, 16'(bus.ras_unf), 16'(e_un));
   endtask

   // Drive one vector, clock it, then sample 1 time unit after the edge
   task automatic apply(vec_t v, string tag);
      logic [127:0] b;
      for (int k = 0; k < 8; k++) b[k*16 +: 16] = 16'(k);
      b[15:0]  = 16'hDEAD;
      b[47:32] = v.s2;
      bus.pc_write = v.pw;
      bus.pc_src   = v.src;
      bus.jcmp     = v.jc;
      bus.comp     = v.cp;
      bus.push     = v.pu;
      bus.pop      = v.po;
      bus.sync_clr = v.sc;
      bus.src_bus  = b;
      @(posedge clk);
      #1;
      chk_all(tag, v.e_pc, v.e_top, v.e_em, v.e_fu, v.e_ov, v.e_un);
   endtask

   initial begin
      vec_t v;
      bus.pc_write = 1'b0; bus.pc_src = '0; bus.jcmp = 1'b0; bus.comp = 1'b0;
      bus.push = 1'b0; bus.pop = 1'b0; bus.sync_clr = 1'b0; bus.src_bus = '0;
      rst_n = 1'b0;

      // Sequential stepping
      for (int i = 1; i <= 6; i++) vecs.push_back(mk(1,0,0,0,0,0,0,16'h2, 16'(2*i),0,1,0,0,0));
      // Each bus slot
      for (int k = 1; k <= 7; k++) vecs.push_back(mk(1,3'(k),0,0,0,0,0,16'h2, 16'(k),0,1,0,0,0));
      // Compare-gated suppression, pcWrite low, suppressed push
      vecs.push_back(mk(1,2,1,0,0,0,0,16'h40, 16'h7,0,1,0,0,0));
      vecs.push_back(mk(0,2,0,0,0,0,0,16'h40, 16'h7,0,1,0,0,0));
      vecs.push_back(mk(1,2,1,0,1,0,0,16'h40, 16'h7,0,1,0,0,0));
      vecs.push_back(mk(1,2,1,1,0,0,0,16'h40, 16'h40,0,1,0,0,0));
      // Call / return
      vecs.push_back(mk(1,2,0,0,0,0,0,16'h10, 16'h10,0,1,0,0,0));
      vecs.push_back(mk(1,2,0,0,1,0,0,16'h80, 16'h80,16'h12,0,0,0,0));
      vecs.push_back(mk(1,2,0,0,0,1,0,16'h80, 16'h12,0,1,0,0,0));
      // push+pop on non-empty and empty stack, pop on empty
      vecs.push_back(mk(1,0,0,0,1,0,0,16'h0, 16'h14,16'h14,0,0,0,0));
      vecs.push_back(mk(1,2,0,0,1,1,0,16'h80, 16'h14,16'h16,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,1,0,16'h0, 16'h16,0,1,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,1,0,16'h0, 16'h16,0,1,0,0,1));
      vecs.push_back(mk(1,0,0,0,1,1,0,16'h0, 16'h16,16'h18,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,0,1,0,16'h0, 16'h18,0,1,0,0,1));
      // syncClr beats push/pop and clears stickies
      vecs.push_back(mk(1,0,0,0,1,1,1,16'h0, 16'h0,0,1,0,0,0));
      // Fill, overflow, drain, underflow
      for (int i = 1; i <= 8; i++)
         vecs.push_back(mk(1,0,0,0,1,0,0,16'h0, 16'(2*i),16'(2*i),0,(i == 8),0,0));
      vecs.push_back(mk(1,0,0,0,1,0,0,16'h0, 16'h12,16'h12,0,1,1,0));
      for (int j = 1; j <= 8; j++)
         vecs.push_back(mk(1,0,0,0,0,1,0,16'h0, 16'(20-2*j),(j == 8) ? 16'h0 : 16'(18-2*j),
                           (j == 8),0,1,0));
      vecs.push_back(mk(1,0,0,0,0,1,0,16'h0, 16'h4,0,1,0,1,1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_all("post-release", 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Async reset mid-run with PC=0xFFFE, three RAS entries, both stickies set
      apply(mk(1,2,0,0,0,0,0,16'hFFFE, 16'hFFFE,0,1,0,1,1), "load_fffe");
      for (int i = 0; i < 3; i++) apply(mk(1,2,0,0,1,0,0,16'hFFFE, 16'hFFFE,16'h0,0,0,1,1),
                                        $sformatf("push3_%0d", i));
      bus.pc_write = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Wraparound
      apply(mk(1,2,0,0,0,0,0,16'hFFFE, 16'hFFFE,0,1,0,0,0), "wrap_load");
      apply(mk(1,0,0,0,0,0,0,16'hFFFE, 16'h0000,0,1,0,0,0), "wrap");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Bound the run in case the stimulus stalls
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
